// File: rtl/sync_fifo_param.sv
// Synchronous FIFO with phase-bit pointers, occupancy count, almost flags
// and one-cycle overflow/underflow pulses for rejected requests.
module sync_fifo_param #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         we,
    input  logic [WIDTH-1:0]             din,
    input  logic                         re,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ph;
    logic             rd_ph;
    logic             rd_ok;
    logic             wr_ok;

    // Status flags come only from registered pointers and count.
    always_comb begin
        empty        = (wr_ptr == rd_ptr) && (wr_ph == rd_ph);
        full         = (wr_ptr == rd_ptr) && (wr_ph != rd_ph);
        almost_full  = (count >= CW'(AF_LEVEL));
        almost_empty = (count <= CW'(AE_LEVEL));
    end

    // Accept decisions; a read frees a slot so a write to a full FIFO may pass.
    always_comb begin
        rd_ok = re && !empty;
        wr_ok = we && (!full || rd_ok);
    end

    // Storage array; contents survive reset and are simply abandoned.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers with phase bits, occupancy, read data and error pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wr_ph     <= 1'b0;
            rd_ph     <= 1'b0;
            count     <= '0;
            dout      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                {wr_ph, wr_ptr} <= {wr_ph, wr_ptr} + (AW + 1)'(1);
            end
            if (rd_ok) begin
                {rd_ph, rd_ptr} <= {rd_ph, rd_ptr} + (AW + 1)'(1);
                dout            <= mem[rd_ptr];
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow  <= we && !wr_ok;
            underflow <= re && !rd_ok;
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed and scoreboard-checked bench for sync_fifo_param, default and small configurations.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rstn;

    // Default configuration: WIDTH=32 DEPTH=16 AF=14 AE=2
    logic        we0, re0;
    logic [31:0] din0, dout0;
    logic        full0, empty0, af0, ae0, ov0, un0;
    logic [4:0]  cnt0;

    // Small configuration: WIDTH=8 DEPTH=4 AF=3 AE=1
    logic        we1, re1;
    logic [7:0]  din1, dout1;
    logic        full1, empty1, af1, ae1, ov1, un1;
    logic [2:0]  cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_param u_dut0 (
        .clk(clk), .rstn(rstn), .we(we0), .din(din0), .re(re0), .dout(dout0),
        .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .count(cnt0), .overflow(ov0), .underflow(un0)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .we(we1), .din(din1), .re(re1), .dout(dout1),
        .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(cnt1), .overflow(ov1), .underflow(un1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags0(input string tag, input bit f, input bit e, input bit afx, input bit aex);
        chk({tag, ".full"}, 32'(full0), 32'(f));
        chk({tag, ".empty"}, 32'(empty0), 32'(e));
        chk({tag, ".almost_full"}, 32'(af0), 32'(afx));
        chk({tag, ".almost_empty"}, 32'(ae0), 32'(aex));
    endtask

    logic [31:0] q0[$];
    logic [7:0]  q1[$];
    logic [31:0] dm0;
    logic [7:0]  dm1;
    bit          rok, wok, eov0, eun0, eov1, eun1;
    int          pw, pr;

    initial begin
        rstn = 1'b0;
        we0 = 0; re0 = 0; din0 = '0;
        we1 = 0; re1 = 0; din1 = '0;

        // Reset values before any clock edge
        #2;
        chk("rst.count", 32'(cnt0), 0);
        chk("rst.dout", dout0, 0);
        chk("rst.ovf", 32'(ov0), 0);
        chk("rst.unf", 32'(un0), 0);
        chk_flags0("rst", 0, 1, 0, 1);
        chk("rst1.count", 32'(cnt1), 0);
        chk("rst1.empty", 32'(empty1), 1);
        step();
        step();
        rstn = 1'b1;

        // Fill with 0..15
        for (int i = 0; i < 16; i++) begin
            we0 = 1; din0 = 32'(i);
            step();
            chk($sformatf("fill%0d.count", i), 32'(cnt0), 32'(i + 1));
            chk_flags0($sformatf("fill%0d", i), i == 15, 0, (i + 1) >= 14, (i + 1) <= 2);
        end
        // 17th write rejected
        din0 = 32'd99;
        step();
        chk("ovf.pulse", 32'(ov0), 1);
        chk("ovf.count", 32'(cnt0), 16);
        we0 = 0;
        step();
        chk("ovf.clear", 32'(ov0), 0);
        chk("ovf.count2", 32'(cnt0), 16);

        // Drain 0..15
        for (int i = 0; i < 16; i++) begin
            re0 = 1;
            step();
            chk($sformatf("drain%0d.dout", i), dout0, 32'(i));
            chk($sformatf("drain%0d.count", i), 32'(cnt0), 32'(15 - i));
            chk($sformatf("drain%0d.empty", i), 32'(empty0), 32'(i == 15));
        end
        step();
        chk("unf.pulse", 32'(un0), 1);
        chk("unf.dout", dout0, 15);
        chk("unf.count", 32'(cnt0), 0);
        re0 = 0;
        step();
        chk("unf.clear", 32'(un0), 0);

        // Refill with 100..115, then write+read while full
        for (int i = 0; i < 16; i++) begin
            we0 = 1; din0 = 32'(100 + i);
            step();
        end
        chk("refill.full", 32'(full0), 1);
        we0 = 1; re0 = 1; din0 = 32'h0000_00AA;
        step();
        chk("fullrw.dout", dout0, 100);
        chk("fullrw.count", 32'(cnt0), 16);
        chk("fullrw.ovf", 32'(ov0), 0);
        chk("fullrw.full", 32'(full0), 1);
        we0 = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("fullrw_rd%0d", i), dout0, (i == 15) ? 32'hAA : 32'(101 + i));
        end
        chk("fullrw.empty", 32'(empty0), 1);

        // Write+read while empty: read rejected, write lands
        we0 = 1; re0 = 1; din0 = 32'h0000_0055;
        step();
        chk("emptyrw.unf", 32'(un0), 1);
        chk("emptyrw.count", 32'(cnt0), 1);
        chk("emptyrw.dout", dout0, 32'hAA);
        we0 = 0;
        step();
        chk("emptyrw.rd", dout0, 32'h55);
        chk("emptyrw.count2", 32'(cnt0), 0);
        chk("emptyrw.unf2", 32'(un0), 0);
        re0 = 0;

        // Mid-operation asynchronous reset with 9 entries
        for (int i = 0; i < 9; i++) begin
            we0 = 1; din0 = 32'(200 + i);
            step();
        end
        we0 = 0;
        chk("pre_arst.count", 32'(cnt0), 9);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst.count", 32'(cnt0), 0);
        chk("arst.empty", 32'(empty0), 1);
        chk("arst.dout", dout0, 0);
        chk("arst.full", 32'(full0), 0);
        step();
        rstn = 1'b1;
        we0 = 1; din0 = 32'h77;
        step();
        chk("post_arst.count", 32'(cnt0), 1);
        we0 = 0; re0 = 1;
        step();
        chk("post_arst.dout", dout0, 32'h77);
        chk("post_arst.empty", 32'(empty0), 1);
        re0 = 0;
        step();

        // Fresh reset, then random traffic against a queue model on both configs
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        dm0 = '0; dm1 = '0;
        for (int c = 0; c < 511; c++) begin
            pw = (c < 170) ? 75 : (c < 340) ? 25 : 50;
            pr = 100 - pw;
            we0 = ($urandom_range(0, 99) < pw); re0 = ($urandom_range(0, 99) < pr);
            we1 = ($urandom_range(0, 99) < 50); re1 = ($urandom_range(0, 99) < 50);
            din0 = 32'(1000 + c);
            din1 = 8'(c);

            rok = re0 && (q0.size() != 0);
            wok = we0 && ((q0.size() != 16) || rok);
            eov0 = we0 && !wok; eun0 = re0 && !rok;
            if (rok) dm0 = q0.pop_front();
            if (wok) q0.push_back(din0);

            rok = re1 && (q1.size() != 0);
            wok = we1 && ((q1.size() != 4) || rok);
            eov1 = we1 && !wok; eun1 = re1 && !rok;
            if (rok) dm1 = q1.pop_front();
            if (wok) q1.push_back(din1);

            step();
            chk($sformatf("r0[%0d].dout", c), dout0, dm0);
            chk($sformatf("r0[%0d].count", c), 32'(cnt0), 32'(q0.size()));
            chk($sformatf("r0[%0d].ovf", c), 32'(ov0), 32'(eov0));
            chk($sformatf("r0[%0d].unf", c), 32'(un0), 32'(eun0));
            chk_flags0($sformatf("r0[%0d]", c), q0.size() == 16, q0.size() == 0,
                       q0.size() >= 14, q0.size() <= 2);
            chk($sformatf("r1[%0d].dout", c), 32'(dout1), 32'(dm1));
            chk($sformatf("r1[%0d].count", c), 32'(cnt1), 32'(q1.size()));
            chk($sformatf("r1[%0d].ovf", c), 32'(ov1), 32'(eov1));
            chk($sformatf("r1[%0d].unf", c), 32'(un1), 32'(eun1));
            chk($sformatf("r1[%0d].full", c), 32'(full1), 32'(q1.size() == 4));
            chk($sformatf("r1[%0d].empty", c), 32'(empty1), 32'(q1.size() == 0));
            chk($sformatf("r1[%0d].af", c), 32'(af1), 32'(q1.size() >= 3));
            chk($sformatf("r1[%0d].ae", c), 32'(ae1), 32'(q1.size() <= 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits, legal range 1..256.
REQ-002 SHALL have parameter DEPTH, default 16: entry count, power of two, legal range 2..1024.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2: almost_full threshold, legal range 1..DEPTH-1.
REQ-004 SHALL have parameter AE_LEVEL, default 2: almost_empty threshold, legal range 1..DEPTH-1.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port we  input  1  write request.
REQ-008 SHALL have port din  input  WIDTH  write data.
REQ-009 SHALL have port re  input  1  read request.
REQ-010 SHALL have port dout  output  WIDTH  registered read data.
REQ-011 SHALL have port full  output  1  count==DEPTH.
REQ-012 SHALL have port empty  output  1  count==0.
REQ-013 SHALL have port almost_full  output  1  count>=AF_LEVEL.
REQ-014 SHALL have port almost_empty  output  1  count<=AE_LEVEL.
REQ-015 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-016 SHALL have port overflow  output  1  one-cycle pulse: rejected write.
REQ-017 SHALL have port underflow  output  1  one-cycle pulse: rejected read.

Function
REQ-018 SHALL store data in a DEPTH x WIDTH circular array addressed by wr_ptr/rd_ptr of $clog2(DEPTH) bits, each wrapping DEPTH-1 -> 0.
REQ-019 SHALL track wrap with a looped/phase bit per pointer; equal pointers with equal phase = empty, differing phase = full.
REQ-020 SHALL accept a read (rd_ok) when re=1 and empty=0, evaluated on pre-edge state.
REQ-021 SHALL accept a write (wr_ok) when we=1 and (full=0 or rd_ok=1); full with simultaneous accepted read passes both.
REQ-022 SHALL, on wr_ok, write din at wr_ptr and advance wr_ptr by 1.
REQ-023 SHALL, on rd_ok, load dout with entry at rd_ptr at the same edge (1-cycle latency from re) and advance rd_ptr.
REQ-024 SHALL hold dout unchanged when rd_ok=0.
REQ-025 SHALL NOT pass data written in a cycle to a read in the same cycle when empty (re ignored when empty, even with we=1).
REQ-026 SHALL update count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither; never exceeds DEPTH nor goes below 0.
REQ-027 SHALL derive full, empty, almost_full, almost_empty combinationally from registered count/pointers only (no path from we/re/din).
REQ-028 SHALL assert overflow for exactly one cycle after an edge where we=1 and wr_ok=0; memory, pointers and count unchanged.
REQ-029 SHALL assert underflow for exactly one cycle after an edge where re=1 and rd_ok=0; dout, pointers and count unchanged.
REQ-030 SHALL preserve FIFO order across any number of pointer wraps.

Reset
REQ-031 SHALL, while rstn=0, force wr_ptr=0, rd_ptr=0, phase bits=0, count=0, dout=0, overflow=0, underflow=0, irrespective of clk.
REQ-032 SHALL output empty=1, full=0, almost_empty=1, almost_full=0 during and immediately after reset.
REQ-033 SHALL treat reset asserted mid-operation as discarding all stored data; array contents need not be cleared.
REQ-034 SHALL accept we/re on the first rising edge after rstn deasserts.

Verification
REQ-035 Default params: reset, write 0..15 with we=1 re=0 -> full=1, count=16, almost_full=1 from count=14; 17th write -> overflow=1 one cycle, count stays 16.
REQ-036 From full, re=1 for 16 cycles -> dout=0..15 in order each 1 cycle after re, empty=1 after last, 17th read -> underflow=1, dout holds 15.
REQ-037 Full FIFO, we=1 re=1 with din=0xAA -> no overflow, count stays 16, 0xAA read out 16th after that cycle.
REQ-038 Empty FIFO, we=1 re=1 din=0x55 -> underflow=1, count=1, dout unchanged; next re -> dout=0x55.
REQ-039 511 cycles random we/re with incrementing din, scoreboard model -> dout order, count, all flags match every cycle across multiple wraps; repeat with WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
REQ-040 Assert rstn=0 between clock edges with count=9 -> count=0, empty=1, dout=0 immediately; post-reset write/read returns new data only.
